fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The module SHALL use one clock; reset is synchronous and active-high.
REQ-003 The port list SHALL be, in order:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- pc_update_control  input  1  redirect request from the jump/branch unit
- pc_update_val  input  32  redirect target
- stall  input  1  decode not ready; the held instruction is not consumed this cycle
- imem_req  output  1  instruction fetch request
- imem_addr  output  32  fetch address, always equal to fetch_pc
- imem_ack  input  1  memory accepts the request and returns data this cycle
- imem_rdata  input  32  instruction word, valid when imem_req && imem_ack
- instr_valid  output  1  instr and instr_pc hold a valid instruction
- instr  output  32  fetched instruction
- instr_pc  output  32  address of instr
- misalign_err  output  1  sticky; a redirect target was not word-aligned

Function
REQ-004 The module SHALL keep an internal 32-bit fetch_pc and a state machine with states BOOT, FETCH, BUBBLE and ERROR.
REQ-005 A fetch handshake SHALL complete in any cycle with imem_req && imem_ack. No request is outstanding across cycles, and dropping imem_req without an ack is legal.
REQ-006 imem_req SHALL equal (state==FETCH) && !pc_update_control && (!instr_valid || !stall).
REQ-007 BOOT SHALL last exactly one cycle with imem_req=0 and then go to FETCH.
REQ-008 On a completed handshake in FETCH, the next edge SHALL load instr<=imem_rdata, instr_pc<=fetch_pc, instr_valid<=1 and fetch_pc<=fetch_pc+4.
REQ-009 fetch_pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-010 When instr_valid && !stall and no handshake completes, instr_valid SHALL clear at the next edge. instr and instr_pc keep their values.
REQ-011 When instr_valid && stall, instr, instr_pc and instr_valid SHALL hold unchanged and no fetch SHALL be issued.
REQ-012 Throughput SHALL be one instruction per cycle when imem_ack=1, stall=0 and there are no redirects. Latency from handshake to instr_valid is one cycle.
REQ-013 A redirect (pc_update_control=1) in FETCH, BUBBLE or BOOT with pc_update_val[1:0]==0 SHALL, at the next edge:
- set fetch_pc<=pc_update_val
- set instr_valid<=0, flushing the held instruction even if stall=1
- enter BUBBLE
REQ-014 BUBBLE SHALL last one cycle with imem_req=0 and then go to FETCH, unless another redirect arrives, which restarts BUBBLE with the new target.
REQ-015 A redirect with pc_update_val[1:0]!=0 SHALL, at the next edge:
- set misalign_err<=1 and instr_valid<=0
- leave fetch_pc unchanged
- enter ERROR
REQ-016 ERROR SHALL keep imem_req=0, instr_valid=0 and misalign_err=1, ignoring all inputs except rst.
REQ-017 A redirect and an imem_ack in the same cycle cannot complete a handshake, per REQ-006. Redirect always wins; no stale instruction ever becomes valid.
REQ-018 imem_addr SHALL be driven from fetch_pc continuously, including when imem_req=0.

Reset
REQ-019 While rst=1 at a clock edge, the module SHALL load:
- fetch_pc=RESET_PC, state=BOOT
- instr_valid=0, instr=0, instr_pc=0, misalign_err=0
REQ-020 During and after any reset cycle, imem_req SHALL be 0 until BOOT has completed.
REQ-021 rst SHALL override a simultaneous redirect, ack or stall. A reset mid-stall or in ERROR returns to the REQ-019 state.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Streaming: RESET_PC=0x100, imem_ack=1, stall=0 -> first imem_req at cycle 2 after reset release; instr_pc = 0x100, 0x104, 0x108 on consecutive cycles with instr_valid=1.
- Stall hold: stall=1 while instr_pc=0x104 is valid -> imem_req=0 and instr/instr_pc stable for every stall cycle; after stall drops, the next instr_pc is 0x108.
- Redirect with collision: pc_update_control=1, pc_update_val=0x2000 in the same cycle as imem_ack=1 -> imem_req=0 that cycle, instr_valid=0 next cycle, one bubble, then imem_addr=0x2000 with imem_req=1.
- Misaligned target: pc_update_val=0x2002 -> misalign_err=1 next cycle, imem_req stays 0 indefinitely; rst -> misalign_err=0 and imem_addr=RESET_PC.
- Wrap-around: redirect to 0xFFFF_FFFC, ack -> instr_pc=0xFFFF_FFFC, then imem_addr=0x0000_0000.
- Reset mid-stall: rst=1 while instr_valid=1, stall=1 -> next cycle instr_valid=0, instr=0, imem_addr=RESET_PC, imem_req=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit.
// Issues single-cycle fetch handshakes from fetch_pc, holds one fetched
// instruction for decode, and handles branch/jump redirects. A redirect to a
// target that is not word-aligned parks the unit in a sticky ERROR state
// that only reset can leave.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_update_control,
   input  logic [31:0] pc_update_val,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        misalign_err
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      BUBBLE = 2'd2,
      ERROR  = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic        handshake;
   logic        target_misaligned;

   // A request must react to a redirect in the same cycle so that a
   // colliding ack can never complete, which is why it is combinational.
   assign imem_req          = (state == FETCH) && !pc_update_control
                              && (!instr_valid || !stall);
   assign handshake         = imem_req && imem_ack;
   assign imem_addr         = fetch_pc;
   assign target_misaligned = (pc_update_val[1:0] != 2'b00);

   // Fetch state machine, program counter and the held instruction register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= BOOT;
         fetch_pc     <= RESET_PC;
         instr_valid  <= 1'b0;
         instr        <= 32'h0000_0000;
         instr_pc     <= 32'h0000_0000;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            BOOT, FETCH, BUBBLE: begin
               if (pc_update_control) begin
                  // Redirect flushes the held instruction even under stall.
                  instr_valid <= 1'b0;
                  if (target_misaligned) begin
                     misalign_err <= 1'b1;
                     state        <= ERROR;
                  end else begin
                     fetch_pc <= pc_update_val;
                     state    <= BUBBLE;
                  end
               end else if (state == FETCH) begin
                  if (handshake) begin
                     instr       <= imem_rdata;
                     instr_pc    <= fetch_pc;
                     instr_valid <= 1'b1;
                     fetch_pc    <= fetch_pc + 32'd4;
                  end else if (instr_valid && !stall) begin
                     // Decode consumed the instruction and nothing replaced it.
                     instr_valid <= 1'b0;
                  end
               end else begin
                  // BOOT and BUBBLE each last a single idle cycle.
                  state <= FETCH;
               end
            end
            ERROR: begin
               instr_valid  <= 1'b0;
               misalign_err <= 1'b1;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Directed scenario tasks drive stimulus
// and push the PCs they expect to be fetched; a monitor pops them whenever a
// handshake completed in the previous cycle and checks the held instruction.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst;
   logic        pc_update_control;
   logic [31:0] pc_update_val;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        misalign_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_q[$];
   logic        pending = 1'b0;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk               (clk),
      .rst               (rst),
      .pc_update_control (pc_update_control),
      .pc_update_val     (pc_update_val),
      .stall             (stall),
      .imem_req          (imem_req),
      .imem_addr         (imem_addr),
      .imem_ack          (imem_ack),
      .imem_rdata        (imem_rdata),
      .instr_valid       (instr_valid),
      .instr             (instr),
      .instr_pc          (instr_pc),
      .misalign_err      (misalign_err)
   );

   // Memory contents are a fixed scramble of the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: a handshake seen at one negedge must show up as the held
   // instruction at the next negedge.
   always @(negedge clk) begin
      logic [31:0] epc;
      if (pending) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got instr_pc %h, expected no fetch", instr_pc);
         end else begin
            epc = exp_q.pop_front();
            if (instr_valid !== 1'b1 || instr_pc !== epc || instr !== mem_word(epc)) begin
               errors++;
               $display("FAIL sb_instr: got valid %b pc %h instr %h, expected valid 1 pc %h instr %h",
                        instr_valid, instr_pc, instr, epc, mem_word(epc));
            end else begin
               $display("instr pc=%h data=%h", instr_pc, instr);
            end
         end
      end
      pending = imem_req && imem_ack && !rst;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; pc_update_control = 1'b0; pc_update_val = 32'h0;
      stall = 1'b0; imem_ack = 1'b0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || misalign_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_regs: got v%b i%h pc%h m%b, expected v0 i0 pc0 m0",
                  instr_valid, instr, instr_pc, misalign_err);
      end
      checks++;
      if (imem_addr !== RST_PC || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_addr: got addr %h req %b, expected addr %h req 0", imem_addr, imem_req, RST_PC);
      end
   endtask

   task automatic test_streaming();
      do_reset();
      rst = 1'b0; imem_ack = 1'b1;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL stream_boot_req: got %b, expected 0", imem_req);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
         errors++; $display("FAIL stream_first_req: got req %b addr %h, expected req 1 addr 00000100", imem_req, imem_addr);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== 32'h100 + 32'(4 * i)) begin
            errors++;
            $display("FAIL stream_seq: got valid %b pc %h, expected valid 1 pc %h", instr_valid, instr_pc, 32'h100 + 32'(4 * i));
         end
      end
      imem_ack = 1'b0;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || instr_pc !== 32'h108) begin
         errors++; $display("FAIL stream_drain: got valid %b pc %h, expected valid 0 pc 00000108", instr_valid, instr_pc);
      end
   endtask

   task automatic test_stall();
      do_reset();
      rst = 1'b0; imem_ack = 1'b1;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      tick(); tick(); tick();
      stall = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h104 || instr !== mem_word(32'h104)) begin
            errors++;
            $display("FAIL stall_hold: got req %b valid %b pc %h instr %h, expected req 0 valid 1 pc 00000104 instr %h",
                     imem_req, instr_valid, instr_pc, instr, mem_word(32'h104));
         end
         tick();
      end
      stall = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
         errors++; $display("FAIL stall_resume: got req %b addr %h, expected req 1 addr 00000108", imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0;
      checks++;
      if (instr_pc !== 32'h108) begin
         errors++; $display("FAIL stall_next_pc: got %h, expected 00000108", instr_pc);
      end
      tick();
   endtask

   task automatic test_redirect_collision();
      do_reset();
      rst = 1'b0; imem_ack = 1'b1;
      exp_q.push_back(32'h100);
      tick(); tick();
      pc_update_control = 1'b1; pc_update_val = 32'h2000;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL redir_req: got %b, expected 0", imem_req);
      end
      tick();
      pc_update_control = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 32'h2000) begin
         errors++;
         $display("FAIL redir_bubble: got valid %b req %b addr %h, expected valid 0 req 0 addr 00002000",
                  instr_valid, imem_req, imem_addr);
      end
      exp_q.push_back(32'h2000);
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin
         errors++; $display("FAIL redir_fetch: got req %b addr %h, expected req 1 addr 00002000", imem_req, imem_addr);
      end
      tick();
      imem_ack = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      do_reset();
      rst = 1'b0;
      tick();
      pc_update_control = 1'b1; pc_update_val = 32'hFFFF_FFFC;
      tick();
      pc_update_control = 1'b0; imem_ack = 1'b1;
      exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0000_0000);
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         errors++; $display("FAIL wrap_req: got req %b addr %h, expected req 1 addr fffffffc", imem_req, imem_addr);
      end
      tick();
      checks++;
      if (instr_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin
         errors++; $display("FAIL wrap_addr: got pc %h addr %h, expected pc fffffffc addr 00000000", instr_pc, imem_addr);
      end
      tick();
      imem_ack = 1'b0;
      tick();
   endtask

   task automatic test_misalign();
      do_reset();
      rst = 1'b0;
      tick();
      pc_update_control = 1'b1; pc_update_val = 32'h2002; imem_ack = 1'b1;
      tick();
      pc_update_control = 1'b0;
      #1;
      checks++;
      if (misalign_err !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== RST_PC) begin
         errors++;
         $display("FAIL misalign_set: got err %b valid %b addr %h, expected err 1 valid 0 addr %h",
                  misalign_err, instr_valid, imem_addr, RST_PC);
      end
      for (int i = 0; i < 4; i++) begin
         pc_update_control = i[0]; pc_update_val = 32'h3000; stall = i[1];
         #1;
         checks++;
         if (imem_req !== 1'b0 || misalign_err !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_hold: got req %b err %b valid %b, expected req 0 err 1 valid 0",
                     imem_req, misalign_err, instr_valid);
         end
         tick();
      end
      rst = 1'b1; pc_update_control = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      tick();
      checks++;
      if (misalign_err !== 1'b0 || imem_addr !== RST_PC || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL misalign_clear: got err %b addr %h req %b, expected err 0 addr %h req 0",
                  misalign_err, imem_addr, imem_req, RST_PC);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      rst = 1'b0; imem_ack = 1'b1;
      exp_q.push_back(32'h100);
      tick(); tick();
      stall = 1'b1; imem_ack = 1'b0;
      tick();
      rst = 1'b1; pc_update_control = 1'b1; pc_update_val = 32'h4000; imem_ack = 1'b1;
      tick();
      checks++;
      if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_addr !== RST_PC || imem_req !== 1'b0) begin
         errors++;
         $display("FAIL rststall_state: got valid %b instr %h addr %h req %b, expected valid 0 instr 0 addr %h req 0",
                  instr_valid, instr, imem_addr, imem_req, RST_PC);
      end
      rst = 1'b0; pc_update_control = 1'b0; stall = 1'b0; imem_ack = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0) begin
         errors++; $display("FAIL rststall_boot: got req %b, expected 0", imem_req);
      end
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         errors++; $display("FAIL rststall_fetch: got req %b addr %h, expected req 1 addr %h", imem_req, imem_addr, RST_PC);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1; pc_update_control = 1'b0; pc_update_val = 32'h0;
      stall = 1'b0; imem_ack = 1'b0;
      test_reset();
      test_streaming();
      test_stall();
      test_redirect_collision();
      test_wrap();
      test_misalign();
      test_reset_mid_stall();
      tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL sb_leftover: got %0d unfetched, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
